// File: rtl/pipe_ctl_fsm_gen_if.sv
// ------------------------------------------------------------------------
// pipe_ctl_fsm_gen_if : command/irq/strobe bundle of the pipeline-control FSM
// rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

interface pipe_ctl_fsm_gen_if #(
  parameter int NSTAGE = 3,
  parameter int NIRQ   = 4,
  parameter int IRQ_W  = 2
);
  logic              pause;
  logic [2:0]        id_cmd;
  logic [NIRQ-1:0]   irq;
  logic [NIRQ-1:0]   irq_mask;
  logic              iack;
  logic [IRQ_W-1:0]  irq_id;
  logic [NSTAGE-1:0] stage_clr;
  logic [NSTAGE-1:0] stage_hold;
  logic [3:0]        pc_prectl;
  logic              zz_is_nop;
  logic              busy;

  modport master (
    output pause, id_cmd, irq, irq_mask,
    input  iack, irq_id, stage_clr, stage_hold, pc_prectl, zz_is_nop, busy
  );

  modport slave (
    input  pause, id_cmd, irq, irq_mask,
    output iack, irq_id, stage_clr, stage_hold, pc_prectl, zz_is_nop, busy
  );
endinterface

`default_nettype wire

// File: rtl/pipe_ctl_fsm_gen.sv
// ------------------------------------------------------------------------
// pipe_ctl_fsm_gen : mips789 pipeline control (stalls, flushes, interrupts)
// rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module pipe_ctl_fsm_gen #(
  parameter int NSTAGE     = 3,
  parameter int MUL_CYCLES = 33,
  parameter int LD_CYCLES  = 1,
  parameter int NIRQ       = 4,
  parameter int IRQ_W      = 2,
  parameter int CNT_W      = 6
) (
  input  logic                clk,
  input  logic                rst,
  pipe_ctl_fsm_gen_if.slave   bus
);

  localparam logic [2:0] CMD_NOI = 3'd0;
  localparam logic [2:0] CMD_CUR = 3'd1;
  localparam logic [2:0] CMD_LD  = 3'd2;
  localparam logic [2:0] CMD_MUL = 3'd3;
  localparam logic [2:0] CMD_RET = 3'd4;

  localparam logic [3:0] PC_IGN = 4'd0;
  localparam logic [3:0] PC_KEP = 4'd1;
  localparam logic [3:0] PC_IRQ = 4'd2;
  localparam logic [3:0] PC_RST = 4'd3;

  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_LAST  = CNT_W'(LD_CYCLES - 1);

  // 4-bit encoding leaves room for illegal codes, which recover through IDLE
  typedef enum logic [3:0] {
    S_RST  = 4'd0,
    S_IDLE = 4'd1,
    S_NOI  = 4'd2,
    S_CUR  = 4'd3,
    S_MUL  = 4'd4,
    S_LD   = 4'd5,
    S_IRQ  = 4'd6,
    S_RET  = 4'd7
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               insvc_q, insvc_d;
  logic [IRQ_W-1:0]   irq_id_q, irq_id_d;

  logic [NIRQ-1:0]    pend;
  logic [IRQ_W-1:0]   win;
  logic               take_irq;
  state_t             nxt;

  logic [NSTAGE-1:0]  clr;
  logic [NSTAGE-1:0]  hold;
  logic [3:0]         pc;
  logic               nop;
  logic               bsy;
  logic               ack;

  function automatic state_t decode_cmd(input logic [2:0] c);
    state_t s;
    case (c)
      CMD_NOI: s = S_NOI;
      CMD_CUR: s = S_CUR;
      CMD_LD:  s = S_LD;
      CMD_MUL: s = S_MUL;
      CMD_RET: s = S_RET;
      default: s = S_IDLE;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_RST;
      cnt_q    <= '0;
      insvc_q  <= 1'b0;
      irq_id_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      insvc_q  <= insvc_d;
      irq_id_q <= irq_id_d;
    end
  end

  always_comb begin
    pend     = bus.irq & bus.irq_mask;
    take_irq = (pend != '0) && !insvc_q;
    nxt      = S_IDLE;
    clr      = '0;
    hold     = '0;
    pc       = PC_IGN;
    nop      = 1'b0;
    bsy      = 1'b0;
    ack      = insvc_q;

    // Scan downward so the lowest pending index wins
    win = '0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (pend[i]) win = IRQ_W'(i);
    end

    case (state_q)
      S_RST: begin
        nxt = S_IDLE;
        clr = '1;
        pc  = PC_RST;
        nop = 1'b1;
      end
      S_IDLE: nxt = take_irq ? S_IRQ : decode_cmd(bus.id_cmd);
      S_NOI:  nxt = decode_cmd(bus.id_cmd);
      S_CUR: begin
        nxt     = S_NOI;
        hold[0] = 1'b1;
        clr[1]  = 1'b1;
        pc      = PC_KEP;
        nop     = 1'b1;
      end
      S_MUL: begin
        nxt    = (cnt_q == MUL_LAST) ? S_IDLE : S_MUL;
        clr[0] = 1'b1;
        pc     = PC_KEP;
        bsy    = 1'b1;
      end
      S_LD: begin
        nxt    = (cnt_q == LD_LAST) ? S_IDLE : S_LD;
        clr[0] = 1'b1;
        pc     = PC_KEP;
        bsy    = 1'b1;
      end
      S_IRQ: begin
        nxt    = S_IDLE;
        clr[0] = 1'b1;
        clr[1] = 1'b1;
        pc     = PC_IRQ;
        ack    = 1'b1;
      end
      S_RET: begin
        nxt = S_IDLE;
        ack = 1'b0;
      end
      default: begin
        nxt = S_IDLE;
        clr = '1;
        pc  = PC_RST;
        nop = 1'b1;
      end
    endcase

    state_d = bus.pause ? state_q : nxt;

    if (state_q == S_MUL || state_q == S_LD) begin
      cnt_d = bus.pause ? cnt_q : cnt_q + 1'b1;
    end else begin
      cnt_d = '0;
    end

    // In-service tracking runs every cycle, even while paused
    insvc_d  = ack;
    irq_id_d = (!bus.pause && state_q == S_IDLE && take_irq) ? win : irq_id_q;
  end

  assign bus.stage_clr  = clr;
  assign bus.stage_hold = hold;
  assign bus.pc_prectl  = pc;
  assign bus.zz_is_nop  = nop;
  assign bus.busy       = bsy;
  assign bus.iack       = ack;
  assign bus.irq_id     = irq_id_q;

endmodule

`default_nettype wire

// File: doc/pipe_ctl_fsm_gen.md
Name: pipe_ctl_fsm_gen

Overview:
- Parametrised pipeline-control FSM for the mips789 core.
- Decodes the decode-stage command, the interrupt lines and the pause input into the following outputs:
  - per-stage clear/hold strobes for NSTAGE pipeline register boundaries;
  - the PC pre-control code;
  - interrupt acknowledge and the winning interrupt ID.
- Generalises the existing controller with configurable multiply/load stall lengths, a prioritised and maskable multi-source interrupt input, and an arbitrary pipeline depth.
- Fixes IDLE decoding so every command is honoured.

Parameters:
- NSTAGE, 3, number of pipeline register boundaries controlled (min 2). Stage 0 = ID→RA, stage 1 = RA→EXEC, stages 2+ = later boundaries.
- MUL_CYCLES, 33, cycles spent in MUL state (1..2^CNT_W).
- LD_CYCLES, 1, cycles spent in LD state (1..2^CNT_W).
- NIRQ, 4, number of interrupt sources.
- IRQ_W, 2, width of irq_id (2^IRQ_W >= NIRQ).
- CNT_W, 6, stall counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- pause  in  1  freezes the state register and stall counter.
- id_cmd  in  3  decode command: 0 NOI, 1 CUR, 2 LD, 3 MUL, 4 RET; 5-7 are reserved.
- irq  in  NIRQ  level interrupt requests.
- irq_mask  in  NIRQ  1 = source enabled.
- iack  out  1  interrupt in service.
- irq_id  out  IRQ_W  index of the accepted interrupt.
- stage_clr  out  NSTAGE  flush strobe per boundary.
- stage_hold  out  NSTAGE  hold strobe per boundary.
- pc_prectl  out  4  PC_IGN/PC_KEP/PC_IRQ/PC_RST codes from mips789_defs.
- zz_is_nop  out  1  inject NOP.
- busy  out  1  high in MUL or LD.

Behaviour:
- States: RST, IDLE, NOI, CUR, MUL, LD, IRQ, RET.
- State register: rst=0 → RST. Otherwise, when pause=0, state <= next; when pause=1, state holds.
- Stall counter cnt (CNT_W bits):
  - rst → 0.
  - In MUL or LD with pause=0: increments.
  - In MUL or LD with pause=1: holds.
  - Any other state: 0.
- pend = irq & irq_mask. insvc = registered iack: rst → 0, else insvc <= iack every cycle, independent of pause.
- Transitions, evaluated in priority order:
  - IDLE:
    1. pend != 0 and insvc = 0 → IRQ.
    2. Otherwise NOI→NOI, CUR→CUR, LD→LD, MUL→MUL, RET→RET.
    3. Reserved command → IDLE.
  - NOI: decodes id_cmd exactly as IDLE but ignores irq.
  - CUR → NOI.
  - MUL → IDLE when cnt == MUL_CYCLES-1, else MUL.
  - LD → IDLE when cnt == LD_CYCLES-1, else LD.
  - IRQ, RET, RST → IDLE.
  - Illegal encoding → IDLE, with outputs as RST.
- irq_id:
  - rst → 0.
  - On the IDLE→IRQ transition (pause=0), latches the lowest set index of pend (index 0 is highest priority).
  - Otherwise holds.
- iack (combinational): 1 in IRQ, 0 in RET, else insvc. A second IRQ is not accepted until RET is executed.
- Outputs per state. Bits not listed are 0; stages >= 2 only ever clear in RST.
  - RST: stage_clr all 1s; PC_RST; zz_is_nop=1.
  - IDLE, NOI, RET: all 0; PC_IGN; nop=0.
  - CUR: stage_hold[0]=1, stage_clr[1]=1; PC_KEP; nop=1.
  - MUL: stage_clr[0]=1; PC_KEP; busy=1.
  - LD: stage_clr[0]=1; PC_KEP; busy=1.
  - IRQ: stage_clr[0]=1, stage_clr[1]=1; PC_IRQ.
- Consequently, after rst deasserts, outputs show RST values for one cycle, then IDLE values.
- Boundary rules:
  - rst asserted mid-MUL/LD: next cycle is RST with cnt=0. insvc is cleared and irq_id=0.
  - pause during IRQ: iack stays 1 and irq_id is stable.
  - An irq that drops before being sampled in IDLE is lost; there is no latching.
- MUL_CYCLES=1 or LD_CYCLES=1: exactly one cycle in that state.

Test Plan:
- Reset: rst=0 for 3 cycles, then 1, with id_cmd=0.
  - Required: RST outputs (stage_clr=3'b111, PC_RST, nop=1) through the first cycle after release, then IDLE, then NOI.
- CUR sequence: from NOI, id_cmd=1 for one cycle, then 0.
  - Required: one cycle of CUR (hold[0]=1, clr[1]=1, PC_KEP, nop=1), then NOI.
- Multiply stall, MUL_CYCLES=33: id_cmd=3 from IDLE, with pause pulsed for 5 cycles mid-stall.
  - Required: busy high for exactly 38 cycles; returns to IDLE; cnt=0 afterwards.
- Interrupt priority: irq=4'b1010, irq_mask=4'b1110 in IDLE.
  - Required: IRQ state, irq_id=1, PC_IRQ, iack=1.
  - Holding irq with no RET: no re-entry to IRQ.
  - id_cmd=4: RET, iack=0, then re-entry with irq_id=1.
- Reserved command: id_cmd=6 in IDLE and in NOI.
  - Required: next state IDLE, all strobes 0, PC_IGN.
- Reset mid-LD, LD_CYCLES=4: rst=0 at cnt=2.
  - Required: next cycle RST with stage_clr all 1s, busy=0, iack=0, irq_id=0.
